hex_scan_display: RTL and testbench

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

---
 rtl/hex_scan_display.sv | 183 ++++++++++++++++++
 tb/tb_hex_scan_display.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// hex_scan_display: multiplexed seven-segment scanner with a debounced channel
// select button. Optional build macro HEX_SCAN_LEADING_BLANK_EN blanks leading
// zero digits (digit 0 is always shown).
module hex_scan_display #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned PRESCALE   = 100000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [CHANNELS*DIGITS*4-1:0]                data,
  input  logic [DIGITS-1:0]                           dp,
  input  logic                                        sel_btn,
  output logic [DIGITS-1:0]                           anode,
  output logic [7:0]                                  catode,
  output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] chan
);

  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned DW = $clog2(DEB_CYCLES);
  localparam int unsigned WW = DIGITS * 4;

  // Active-low glyph for one hex nibble, segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

`ifdef HEX_SCAN_LEADING_BLANK_EN
  // Marks digits that sit in the run of zeros above the first nonzero digit
  function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [WW-1:0] w);
    logic zero_run;
    logic [DIGITS-1:0] m;
    zero_run = 1'b1;
    m        = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run = zero_run & (w[i*4 +: 4] == 4'h0);
      m[i]     = zero_run;
    end
    return m;
  endfunction
`endif

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              run_q, run_d;
  logic [WW-1:0]     snap_q, snap_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [7:0]        catode_q, catode_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [DW-1:0]     deb_cnt_q, deb_cnt_d;
  logic              deb_lvl_q, deb_lvl_d;
  logic [CW-1:0]     chan_q, chan_d;

  logic              tick;
  logic              frame_start;
  logic              press;
  logic [WW-1:0]     live_word;
  logic [3:0]        nib;
  logic [6:0]        seg;
`ifdef HEX_SCAN_LEADING_BLANK_EN
  logic [DIGITS-1:0] blank_mask;
`endif

  // Next-state logic for scan timing, frame snapshot, outputs and button path
  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    run_d     = run_q;
    snap_d    = snap_q;
    anode_d   = anode_q;
    catode_d  = catode_q;
    sync1_d   = sel_btn;
    sync2_d   = sync1_q;
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    chan_d    = chan_q;
    press     = 1'b0;

    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);

    // First tick after reset lands on digit 0; later ticks step and wrap
    if (tick) begin
      run_d = 1'b1;
      if (!run_q || idx_q == IW'(DIGITS - 1)) idx_d = '0;
      else                                    idx_d = idx_q + IW'(1);
    end

    // Frame snapshot uses the channel selected before any same-cycle press
    live_word   = data[chan_q*WW +: WW];
    frame_start = tick && (idx_d == '0);
    if (frame_start) snap_d = live_word;

    nib = snap_d[idx_d*4 +: 4];
    seg = hex7(nib);
`ifdef HEX_SCAN_LEADING_BLANK_EN
    blank_mask = lead_zero_mask(snap_d);
    if (blank_mask[idx_d]) seg = 7'h7F;
`endif

    if (tick) begin
      anode_d       = ~(DIGITS'(1) << idx_d);
      catode_d[6:0] = seg;
    end
    // Decimal point tracks dp every cycle once scanning has started
    catode_d[7] = run_d ? ~dp[idx_d] : 1'b1;

    // Debounce: level follows the synchronized input after a stable run
    if (sync2_q != deb_lvl_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_lvl_d = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end

    press = deb_lvl_d & ~deb_lvl_q;
    if (press) begin
      if (chan_q == CW'(CHANNELS - 1)) chan_d = '0;
      else                             chan_d = chan_q + CW'(1);
    end
  end

  // State registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      run_q     <= 1'b0;
      snap_q    <= '0;
      anode_q   <= '1;
      catode_q  <= 8'hFF;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      deb_lvl_q <= 1'b0;
      chan_q    <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      snap_q    <= snap_d;
      anode_q   <= anode_d;
      catode_q  <= catode_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_cnt_q <= deb_cnt_d;
      deb_lvl_q <= deb_lvl_d;
      chan_q    <= chan_d;
    end
  end

  assign anode  = anode_q;
  assign catode = catode_q;
  assign chan   = chan_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Self-checking bench for hex_scan_display with small timing parameters.
module tb_hex_scan_display;

  localparam int D  = 4;
  localparam int C  = 4;
  localparam int P  = 4;
  localparam int DB = 8;

  logic            clk;
  logic            reset;
  logic [C*D*4-1:0] data;
  logic [D-1:0]    dp;
  logic            sel_btn;
  logic [D-1:0]    anode;
  logic [7:0]      catode;
  logic [1:0]      chan;

  int n_chk;
  int n_err;
  bit chk_en;

  hex_scan_display #(
    .DIGITS(D), .CHANNELS(C), .PRESCALE(P), .DEB_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .dp(dp), .sel_btn(sel_btn),
    .anode(anode), .catode(catode), .chan(chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference glyphs, full bytes with the dp bit shown as 1
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [6:0] ref_seg(input logic [15:0] w, input int digit);
    int n;
    logic [7:0] g;
    n = int'((w >> (digit * 4)) & 16'hF);
    g = seg_tab[n];
`ifdef HEX_SCAN_LEADING_BLANK_EN
    if (digit != 0 && (w >> (digit * 4)) == 16'h0) g = 8'hFF;
`endif
    return g[6:0];
  endfunction

  // Behavioural model: time since reset decides slot, digit and frame start
  int          m_cyc;
  int          m_chan;
  int          m_run;
  bit          m_level;
  bit          m_h1, m_h2;
  logic [15:0] m_snap;
  logic [3:0]  exp_anode;
  logic [7:0]  exp_catode;

  always @(posedge clk) begin
    bit synced;
    int digit;
    if (reset) begin
      m_cyc = 0; m_chan = 0; m_run = 0; m_level = 0; m_h1 = 0; m_h2 = 0;
      m_snap = '0; exp_anode = 4'hF; exp_catode = 8'hFF;
    end else begin
      m_cyc++;
      synced = m_h2; m_h2 = m_h1; m_h1 = sel_btn;
      digit = (m_cyc / P - 1) % D;
      if (m_cyc % P == 0) begin
        if (digit == 0) m_snap = data[m_chan*16 +: 16];
        exp_anode = ~(4'b1 << digit);
        exp_catode[6:0] = ref_seg(m_snap, digit);
      end
      if (m_cyc >= P) exp_catode[7] = ~dp[digit];
      if (synced != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = synced;
          m_run = 0;
          if (synced) m_chan = (m_chan + 1) % C;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // Every cycle, outputs must follow the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("anode", 32'(anode), 32'(exp_anode));
      check("catode", 32'(catode), 32'(exp_catode));
      check("chan", 32'(chan), 32'(m_chan));
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    check("rst_anode", 32'(anode), 32'h0000000F);
    check("rst_catode", 32'(catode), 32'h000000FF);
    check("rst_chan", 32'(chan), 32'h0);
  endtask

  task automatic next_slot();
    repeat (P) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input int n);
    sel_btn = 1'b1;
    repeat (n) @(negedge clk);
    sel_btn = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_digit0();
    for (int i = 0; i < 64 && anode !== 4'hE; i++) @(negedge clk);
    check("wait_digit0", 32'(anode), 32'h0000000E);
  endtask

  logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] ca_seq [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
  logic [7:0] blank_exp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    n_chk = 0; n_err = 0; chk_en = 0;
    reset = 1'b1; sel_btn = 1'b0; dp = '0; data = '0;

    // Basic scan of 12AF on channel 0
    data[15:0] = 16'h12AF;
    do_reset(2);
    chk_en = 1;
    for (int k = 0; k < 8; k++) begin
      next_slot();
      check($sformatf("scan_anode%0d", k), 32'(anode), 32'(an_seq[k % 4]));
      check($sformatf("scan_catode%0d", k), 32'(catode), 32'(ca_seq[k % 4]));
    end

    // Decimal point on digit 2 only
    dp = 4'b0100;
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      next_slot();
      check($sformatf("dp_bit%0d", k), 32'(catode[7]), (k == 2) ? 32'h0 : 32'h1);
    end
    dp = '0;

    // Mid-frame data change must not tear the current frame
    data[15:0] = 16'h0000;
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      next_slot();
      check($sformatf("tear_old%0d", k), 32'(catode), 32'h000000C0);
    end
    data[15:0] = 16'hFFFF;
    next_slot();
    check("tear_old3", 32'(catode), 32'h000000C0);
    for (int k = 0; k < 4; k++) begin
      next_slot();
      check($sformatf("tear_new%0d", k), 32'(catode), 32'h0000008E);
    end

    // Debounce: short pulse rejected, long pulses counted and wrap
    do_reset(1);
    press(5);
    check("deb_short", 32'(chan), 32'h0);
    press(20);
    check("deb_long1", 32'(chan), 32'h1);
    press(20);
    check("deb_long2", 32'(chan), 32'h2);
    press(20);
    check("deb_long3", 32'(chan), 32'h3);
    press(20);
    check("deb_wrap", 32'(chan), 32'h0);

    // Channel 1 with leading zeros
    data[31:16] = 16'h00A0;
    press(20);
    check("ch1_sel", 32'(chan), 32'h1);
    repeat (20) @(negedge clk);
    wait_digit0();
`ifdef HEX_SCAN_LEADING_BLANK_EN
    blank_exp = 8'hFF;
`else
    blank_exp = 8'hC0;
`endif
    check("ch1_d0", 32'(catode), 32'h000000C0);
    next_slot();
    check("ch1_d1", 32'(catode), 32'h00000088);
    next_slot();
    check("ch1_d2", 32'(catode), 32'(blank_exp));
    next_slot();
    check("ch1_d3", 32'(catode), 32'(blank_exp));

    // One-cycle reset mid-frame
    repeat (6) @(negedge clk);
    do_reset(1);
    repeat (3) @(negedge clk);
    check("rst_still_blank", 32'(anode), 32'h0000000F);
    @(negedge clk);
    check("rst_first_d0", 32'(anode), 32'h0000000E);
    check("rst_first_chan", 32'(chan), 32'h0);

    // Randomized traffic checked by the model every cycle
    hold = 5;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7, 0) == 0) begin
        for (int j = 0; j < C; j++)
          data[j*16 +: 16] = ($urandom_range(3, 0) == 0) ? 16'($urandom_range(255, 0))
                                                         : 16'($urandom);
      end
      if ($urandom_range(7, 0) == 0) dp = 4'($urandom);
      if (hold == 0) begin
        sel_btn = ~sel_btn;
        hold = $urandom_range(25, 1);
      end else begin
        hold--;
      end
      reset = ($urandom_range(499, 0) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
